dcache_dm: RTL
==============

# dcache_dm

Parametrised direct-mapped, write-through, no-write-allocate data cache for the RISC-V core's memory stage, replacing the flat combinational data array. Serves LB/LBU/LH/LHU/LW loads and SB/SH/SW stores from the CPU side. Refills lines from, and writes through to, a word-wide backing memory over a per-beat req/ack handshake. Stalls the pipeline on misses and stores.

## Interface
- `NUM_LINES`, 16: cache lines, power of two ≥ 2.
- `LINE_WORDS`, 4: 32-bit words per line, power of two ≥ 2.
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `cpu_req` in 1: access valid this cycle.
- `cpu_we` in 1: 1 = store, 0 = load.
- `cpu_size` in 2: 00 byte, 01 half, 10 word; 11 treated as word.
- `cpu_unsigned` in 1: zero-extend loads (LBU/LHU).
- `cpu_addr` in 32: byte address.
- `cpu_wdata` in 32: store data, right-aligned.
- `cpu_rdata` out 32: extended load result.
- `cpu_stall` out 1: CPU must hold all `cpu_*` inputs stable.
- `cpu_misalign` out 1: misaligned access flag.
- `mem_req` out 1: memory beat request.
- `mem_we` out 1: beat is a write.
- `mem_addr` out 32: word-aligned beat address.
- `mem_wdata` out 32: lane-aligned write data.
- `mem_be` out 4: write byte enables.
- `mem_rdata` in 32: read data, valid with `mem_ack`.
- `mem_ack` in 1: beat complete this cycle.

## Operation
- Address split, LSB up:
  - byte offset [1:0].
  - word select, log2(LINE_WORDS) bits.
  - index, log2(NUM_LINES) bits.
  - tag, remaining bits.
- Per line: valid bit, tag, LINE_WORDS words. Hit = valid[index] && tag match.
- Misaligned access: half with addr[0]=1, or word with addr[1:0]≠0.
  - `cpu_misalign`=1, `cpu_stall`=0, `cpu_rdata`=0.
  - No cache or memory activity, no state change.
- FSM states: IDLE, REFILL, WRITE.
- IDLE, load hit:
  - Combinational response in the same cycle: byte/half selected by addr[1:0], sign- or zero-extended to 32 bits.
  - `cpu_stall`=0.
- IDLE, load miss: `cpu_stall`=1; beat counter cleared; next state REFILL.
- IDLE, store (hit or miss): `cpu_stall`=1; next state WRITE.
- REFILL:
  - `mem_req`=1, `mem_we`=0, `mem_addr` = line base + 4·count.
  - Each `mem_ack` writes `mem_rdata` into the line and increments count.
  - On the ack of beat LINE_WORDS−1: set valid, write tag, go to IDLE.
  - Previous line contents are discarded; write-through means there is no dirty data.
- WRITE:
  - `mem_req`=1, `mem_we`=1, `mem_addr` = word address.
  - `mem_wdata` is replicated onto the lanes: byte ×4, half ×2.
  - `mem_be`: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111.
  - In the `mem_ack` cycle, if the line hits, the enabled bytes are merged into the cached word. A store miss leaves the cache unchanged (no allocate).
  - Then go to IDLE.
- `cpu_stall` truth:
  - IDLE: `cpu_req` && !misalign && (`cpu_we` || miss).
  - REFILL: 1.
  - WRITE: !`mem_ack`.
- Outside REFILL and WRITE: `mem_req`=0, `mem_we`=0, `mem_be`=0.

## Timing
- Reset (asynchronous assert, synchronous deassert by system):
  - state IDLE, count 0, all valid bits 0.
  - `mem_req`=0, `mem_we`=0, `mem_be`=0, `cpu_stall`=0, `cpu_misalign`=0, `cpu_rdata`=0.
  - Data and tag arrays are not reset.
- Load hit latency: 0 cycles (combinational read).
- Load miss latency: miss cycle + LINE_WORDS acked beats + 1. The hit is served in IDLE the cycle after the last ack.
- Store latency: request cycle + cycles to `mem_ack`. The CPU advances in the ack cycle.
- `mem_req` and `mem_addr` stay stable until ack. `mem_ack` is sampled only while `mem_req`=1. An ack in the same cycle as the request is legal.
- Reset asserted mid-REFILL: refill aborts; the line stays invalid; any partial words are harmless.
- Reset mid-WRITE: request dropped; the memory side must tolerate an abandoned beat.
- Count wraps to 0 after beat LINE_WORDS−1.
- Loads to the line being refilled are not serviced early.

## Structure
- Package `dcache_pkg`:
  - size encodings (SZ_B, SZ_H, SZ_W).
  - FSM state enum.
  - localparam helpers for offset/index/tag widths.
- Sub-module `dcache_lane_align` (combinational):
  - load extract/extend from a 32-bit word.
  - store lane replication and `mem_be` generation.
  - shared by the read and write paths.
- Top level holds the arrays, FSM and counter.

## Test plan
- Reset, LW 0x40 (miss), memory acks 0x11,0x22,0x33,0x44 at 0x40..0x4C with 0 wait states → `mem_addr` 0x40,0x44,0x48,0x4C; stall 5 cycles; `cpu_rdata`=0x11; following LW 0x48 hits with stall 0, data 0x33.
- After the line above holds 0x80FF7F01 at 0x40:
  - LB 0x43 → 0xFFFFFF80.
  - LBU 0x43 → 0x00000080.
  - LH 0x42 → 0xFFFF80FF.
  - LHU 0x40 → 0x00007F01.
- SB 0x41 data 0xAB on a hit line → `mem_be`=0010, `mem_wdata`=0xABABABAB; after ack, LW 0x40 hits and returns the merged word with byte1=0xAB.
- SW to an uncached address 0x200 → one write beat; a following LW 0x200 misses (no allocate).
- LH 0x41, LW 0x42 → `cpu_misalign`=1, stall 0, no `mem_req`.
- Alias eviction: LW 0x40 then LW 0x40+NUM_LINES·LINE_WORDS·4 both miss. Reset pulsed during beat 2 of a refill → `mem_req` drops, and the next LW 0x40 misses again.

Source files
------------

// File: rtl/dcache_pkg.sv
// dcache_pkg
// Shared definitions for the direct-mapped data cache:
//   - CPU access size encodings (SZ_B, SZ_H, SZ_W; 2'b11 behaves as a word)
//   - FSM state type and state constants
//   - helpers that derive the address field widths from the geometry
package dcache_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_REFILL = 2'd1;
  localparam state_t ST_WRITE  = 2'd2;

  // Byte offset inside a 32-bit word.
  localparam int OFFSET_W = 2;

  function automatic int word_sel_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int index_w(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int tag_w(input int num_lines, input int line_words);
    return 32 - OFFSET_W - $clog2(line_words) - $clog2(num_lines);
  endfunction

endpackage

// File: rtl/dcache_lane_align.sv
// dcache_lane_align
// Combinational byte-lane logic shared by the load and store paths.
// Ports:
//   size, is_unsigned, byte_off : access size, zero-extend flag, addr[1:0]
//   rd_word     -> ld_data      : 32-bit word in, extracted/extended load value out
//   st_data_in  -> st_data_out  : right-aligned store data in, lane-replicated data out
//   st_be                       : byte enables for the store
module dcache_lane_align
  import dcache_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  byte_off,
  input  logic [31:0] rd_word,
  output logic [31:0] ld_data,
  input  logic [31:0] st_data_in,
  output logic [31:0] st_data_out,
  output logic [3:0]  st_be
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    case (byte_off)
      2'd0:    sel_byte = rd_word[7:0];
      2'd1:    sel_byte = rd_word[15:8];
      2'd2:    sel_byte = rd_word[23:16];
      default: sel_byte = rd_word[31:24];
    endcase
    // Halves are always aligned here, so only addr[1] picks the half.
    sel_half = byte_off[1] ? rd_word[31:16] : rd_word[15:0];

    case (size)
      SZ_B:    ld_data = {{24{~is_unsigned & sel_byte[7]}}, sel_byte};
      SZ_H:    ld_data = {{16{~is_unsigned & sel_half[15]}}, sel_half};
      default: ld_data = rd_word;
    endcase
  end

  // Replicating the data onto every lane lets the byte enables alone pick
  // the target bytes, both for memory and for the cached-word merge.
  always_comb begin
    case (size)
      SZ_B: begin
        st_data_out = {4{st_data_in[7:0]}};
        st_be       = 4'b0001 << byte_off;
      end
      SZ_H: begin
        st_data_out = {2{st_data_in[15:0]}};
        st_be       = 4'b0011 << byte_off;
      end
      default: begin
        st_data_out = st_data_in;
        st_be       = 4'b1111;
      end
    endcase
  end

endmodule

// File: rtl/dcache_dm.sv
// dcache_dm
// Direct-mapped, write-through, no-write-allocate data cache.
// Ports:
//   clock, reset (async, active-low)
//   cpu_req/we/size/unsigned/addr/wdata : CPU access, held stable while stalled
//   cpu_rdata, cpu_stall, cpu_misalign  : CPU response
//   mem_req/we/addr/wdata/be            : backing-memory beat request
//   mem_rdata, mem_ack                  : backing-memory beat completion
module dcache_dm
  import dcache_pkg::*;
#(
  parameter int NUM_LINES  = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_unsigned,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        cpu_misalign,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int WSEL_W = word_sel_w(LINE_WORDS);
  localparam int IDX_W  = index_w(NUM_LINES);
  localparam int TAG_W  = tag_w(NUM_LINES, LINE_WORDS);
  localparam logic [WSEL_W-1:0] LAST_BEAT = WSEL_W'(LINE_WORDS - 1);

  logic [WSEL_W-1:0] word_sel;
  logic [IDX_W-1:0]  index;
  logic [TAG_W-1:0]  tag;

  state_t            state_q, state_d;
  logic [WSEL_W-1:0] count_q, count_d;
  logic [NUM_LINES-1:0] valid_q, valid_d;

  logic [31:0]      data_q [NUM_LINES*LINE_WORDS];
  logic [TAG_W-1:0] tag_q  [NUM_LINES];

  logic                    data_we;
  logic [IDX_W+WSEL_W-1:0] data_waddr;
  logic [31:0]             data_wdata;
  logic                    tag_we;

  logic        hit;
  logic        misalign;
  logic        access;
  logic [31:0] rd_word;
  logic [31:0] ld_data;
  logic [31:0] st_data;
  logic [3:0]  st_be;
  logic [31:0] merged_word;

  assign word_sel = cpu_addr[OFFSET_W +: WSEL_W];
  assign index    = cpu_addr[OFFSET_W+WSEL_W +: IDX_W];
  assign tag      = cpu_addr[31 -: TAG_W];

  assign rd_word  = data_q[{index, word_sel}];
  assign hit      = valid_q[index] && (tag_q[index] == tag);

  // Size 2'b11 shares the word alignment rule through size[1].
  assign misalign = cpu_req &&
                    (((cpu_size == SZ_H) && cpu_addr[0]) ||
                     (cpu_size[1] && (cpu_addr[1:0] != 2'b00)));
  assign access   = cpu_req && !misalign;

  dcache_lane_align u_lane_align (
    .size        (cpu_size),
    .is_unsigned (cpu_unsigned),
    .byte_off    (cpu_addr[1:0]),
    .rd_word     (rd_word),
    .ld_data     (ld_data),
    .st_data_in  (cpu_wdata),
    .st_data_out (st_data),
    .st_be       (st_be)
  );

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      merged_word[8*i +: 8] = st_be[i] ? st_data[8*i +: 8] : rd_word[8*i +: 8];
    end
  end

  // Main control: IDLE serves hits combinationally and launches refills or
  // write-through beats; REFILL streams a whole line in, WRITE sends one beat.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    valid_d      = valid_q;
    data_we      = 1'b0;
    data_waddr   = {index, word_sel};
    data_wdata   = merged_word;
    tag_we       = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = 32'h0;
    mem_wdata    = 32'h0;
    mem_be       = 4'b0000;
    cpu_stall    = 1'b0;
    cpu_rdata    = 32'h0;
    cpu_misalign = misalign;

    case (state_q)
      ST_IDLE: begin
        if (access) begin
          if (cpu_we) begin
            cpu_stall = 1'b1;
            state_d   = ST_WRITE;
          end else if (hit) begin
            cpu_rdata = ld_data;
          end else begin
            cpu_stall = 1'b1;
            count_d   = '0;
            state_d   = ST_REFILL;
          end
        end
      end

      ST_REFILL: begin
        cpu_stall = 1'b1;
        mem_req   = 1'b1;
        mem_addr  = {tag, index, count_q, 2'b00};
        if (mem_ack) begin
          data_we    = 1'b1;
          data_waddr = {index, count_q};
          data_wdata = mem_rdata;
          count_d    = count_q + 1'b1;
          // The line only becomes visible once every word has arrived.
          if (count_q == LAST_BEAT) begin
            valid_d[index] = 1'b1;
            tag_we         = 1'b1;
            state_d        = ST_IDLE;
          end
        end
      end

      ST_WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {cpu_addr[31:2], 2'b00};
        mem_wdata = st_data;
        mem_be    = st_be;
        cpu_stall = !mem_ack;
        if (mem_ack) begin
          // Only a resident line is updated; a store miss never allocates.
          data_we = hit;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Data and tag storage carry no reset; the valid bits guard them.
  always_ff @(posedge clock) begin
    if (data_we) begin
      data_q[data_waddr] <= data_wdata;
    end
    if (tag_we) begin
      tag_q[index] <= tag;
    end
  end

endmodule
